dram_responder: RTL

- Memory-side responder for the accelerator's DRAM request interface. It serves the word reads and writes issued by the layer engines (conv, pool, fc).
- Holds a word-addressed array. It returns read data after a fixed, parameterised latency with dram_valid. Writes commit in the cycle they are issued.
- A secondary host port preloads weights and input maps and dumps output maps. It is serviced only when the engine port is idle.
- Provides access counters and a sticky out-of-range error flag for verification and bring-up.

---
 rtl/dram_responder.sv | 110 +++++++++++
 1 files changed

// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - word-addressed DRAM model serving engine reads/writes plus an idle-time host port
module dram_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 18,
  parameter int DEPTH        = 8192,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  dram_en_rd,
  input  logic [ADDR_WIDTH-1:0] dram_addr_rd,
  output logic [DATA_WIDTH-1:0] dram_rdata,
  output logic                  dram_valid,
  input  logic                  dram_en_wr,
  input  logic [ADDR_WIDTH-1:0] dram_addr_wr,
  input  logic [DATA_WIDTH-1:0] dram_wdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_ack,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt,
  output logic                  err_oob
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  rd_oob, wr_oob, host_oob, host_grant;
  logic [DATA_WIDTH-1:0] rd_word, host_word;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] mem_wd;

  logic [READ_LATENCY-1:0] v_pipe;
  logic [DATA_WIDTH-1:0]   d_pipe [READ_LATENCY];

  assign rd_oob   = dram_addr_rd >= DEPTH_A;
  assign wr_oob   = dram_addr_wr >= DEPTH_A;
  assign host_oob = host_addr >= DEPTH_A;
  // Engine always wins; the ack cycle itself is never a grant cycle.
  assign host_grant = host_req && !dram_en_rd && !dram_en_wr && !host_ack;

  always_comb begin
    rd_word = '0;
    if (!rd_oob) begin
      // Write-first on a same-cycle collision.
      if (dram_en_wr && !wr_oob && dram_addr_wr == dram_addr_rd)
        rd_word = dram_wdata;
      else
        rd_word = mem[dram_addr_rd[IDX_W-1:0]];
    end
    host_word = host_oob ? '0 : mem[host_addr[IDX_W-1:0]];

    mem_we  = 1'b0;
    mem_idx = dram_addr_wr[IDX_W-1:0];
    mem_wd  = dram_wdata;
    if (dram_en_wr && !wr_oob) begin
      mem_we = 1'b1;
    end else if (host_grant && host_we && !host_oob) begin
      mem_we  = 1'b1;
      mem_idx = host_addr[IDX_W-1:0];
      mem_wd  = host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wd;
  end

  // Data in each stage only advances behind a valid, so the last stage holds between returns.
  always_ff @(posedge clk) begin
    if (srst) begin
      v_pipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) d_pipe[i] <= '0;
    end else begin
      v_pipe[0] <= dram_en_rd;
      if (dram_en_rd) d_pipe[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        if (v_pipe[i-1]) d_pipe[i] <= d_pipe[i-1];
      end
    end
  end

  assign dram_valid = v_pipe[READ_LATENCY-1];
  assign dram_rdata = d_pipe[READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (srst) begin
      host_ack   <= 1'b0;
      host_rdata <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      err_oob    <= 1'b0;
    end else begin
      host_ack <= host_grant;
      if (host_grant && !host_we) host_rdata <= host_word;
      if (dram_en_rd) rd_cnt <= rd_cnt + 32'd1;
      if (dram_en_wr) wr_cnt <= wr_cnt + 32'd1;
      if ((dram_en_rd && rd_oob) || (dram_en_wr && wr_oob) || (host_grant && host_oob))
        err_oob <= 1'b1;
    end
  end

endmodule
